// File: rtl/io_cond_pkg.sv
// Shared defaults and helpers for the board input conditioner.
package io_cond_pkg;

    localparam int unsigned SAMPLE_CYCLES_1MS = 50000;
    localparam int unsigned STABLE_TICKS_DEF  = 5;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/io_debounce_cell.sv
// One-bit synchronizer plus tick-sampled debouncer with a registered activation strobe.
module io_debounce_cell
    import io_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF,
    parameter logic        RST_VAL      = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int unsigned CW = cnt_w(STABLE_TICKS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
        end
    end

    // o_rise marks the move away from the idle (reset) level, whatever its polarity.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_d   = 1'b0;
        if (i_tick) begin
            if (synced != stable_q) begin
                if (cnt_q == CW'(STABLE_TICKS - 1)) begin
                    stable_d = ~stable_q;
                    cnt_d    = '0;
                    rise_d   = (stable_q == RST_VAL);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stable_q <= RST_VAL;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
        end
    end

    assign o_level = stable_q;
    assign o_rise  = rise_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Conditions raw KEY/SW inputs: synchronize, debounce on a shared tick, latch button presses.
module io_input_conditioner
    import io_cond_pkg::*;
#(
    parameter int unsigned N_BTN          = 4,
    parameter int unsigned N_SW           = 10,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SAMPLE_CYCLES  = SAMPLE_CYCLES_1MS,
    parameter int unsigned STABLE_TICKS   = STABLE_TICKS_DEF,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_BTN-1:0] i_btn_raw,
    input  logic [N_SW-1:0]  i_sw_raw,
    input  logic [N_BTN-1:0] i_press_clr,
    output logic [N_BTN-1:0] o_btn,
    output logic [N_BTN-1:0] o_btn_pulse,
    output logic [N_BTN-1:0] o_btn_press,
    output logic [N_SW-1:0]  o_sw
);

    localparam int unsigned TW       = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic        BTN_IDLE = BTN_ACTIVE_LOW;

    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic             tick;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_SW-1:0]  sw_rise_unused;

    assign tick = (tick_cnt_q == TW'(SAMPLE_CYCLES - 1));

    always_comb begin
        tick_cnt_d = tick_cnt_q + TW'(1);
        if (tick) begin
            tick_cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : gen_btn
        io_debounce_cell #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_TICKS(STABLE_TICKS),
            .RST_VAL     (BTN_IDLE)
        ) u_cell (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .i_tick (tick),
            .i_raw  (i_btn_raw[g]),
            .o_level(o_btn[g]),
            .o_rise (o_btn_pulse[g])
        );
    end

    for (genvar g = 0; g < N_SW; g++) begin : gen_sw
        io_debounce_cell #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_TICKS(STABLE_TICKS),
            .RST_VAL     (1'b0)
        ) u_cell (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .i_tick (tick),
            .i_raw  (i_sw_raw[g]),
            .o_level(o_sw[g]),
            .o_rise (sw_rise_unused[g])
        );
    end

    // A new press outranks a clear landing in the same cycle.
    always_comb begin
        press_d = (press_q & ~i_press_clr) | o_btn_pulse;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            press_q <= '0;
        end else begin
            press_q <= press_d;
        end
    end

    assign o_btn_press = press_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Randomized and directed checks of io_input_conditioner against a behavioural model.
module tb_io_input_conditioner;

    localparam int unsigned NB = 4;
    localparam int unsigned NS = 10;
    localparam int unsigned NT = NB + NS;
    localparam int unsigned SY = 2;
    localparam int unsigned S  = 4;
    localparam int unsigned ST = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn_raw, press_clr;
    logic [NS-1:0] sw_raw;
    logic [NB-1:0] o_btn, o_btn_pulse, o_btn_press;
    logic [NS-1:0] o_sw;

    io_input_conditioner #(
        .N_BTN         (NB),
        .N_SW          (NS),
        .SYNC_STAGES   (SY),
        .SAMPLE_CYCLES (S),
        .STABLE_TICKS  (ST),
        .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_btn_raw  (btn_raw),
        .i_sw_raw   (sw_raw),
        .i_press_clr(press_clr),
        .o_btn      (o_btn),
        .o_btn_pulse(o_btn_pulse),
        .o_btn_press(o_btn_press),
        .o_sw       (o_sw)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: {sw, btn} levels, raw history seen through the synchronizer delay,
    // and a run length of consecutive differing samples per bit.
    logic [NT-1:0] idle_vec;
    logic [NT-1:0] m_level;
    logic [NB-1:0] m_pulse, m_press;
    int            m_run[NT];
    int            m_edges;
    logic [NT-1:0] m_hist[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = idle_vec;
        m_pulse = '0;
        m_press = '0;
        m_edges = 0;
        for (int i = 0; i < NT; i++) m_run[i] = 0;
        m_hist.delete();
        for (int i = 0; i < SY; i++) m_hist.push_front(idle_vec);
    endtask

    task automatic model_edge();
        logic [NT-1:0] synced;
        bit            tick;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tick = ((m_edges % S) == S - 1);
        m_edges++;
        synced = m_hist.pop_back();
        m_hist.push_front({sw_raw, btn_raw});
        m_press = (m_press & ~press_clr) | m_pulse;
        m_pulse = '0;
        if (tick) begin
            for (int b = 0; b < NT; b++) begin
                if (synced[b] !== m_level[b]) begin
                    m_run[b]++;
                    if (m_run[b] == ST) begin
                        m_level[b] = synced[b];
                        m_run[b]   = 0;
                        if (b < NB && synced[b] == 1'b0) m_pulse[b] = 1'b1;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("btn", 32'(o_btn), 32'(m_level[NB-1:0]));
        check_eq("sw", 32'(o_sw), 32'(m_level[NT-1:NB]));
        check_eq("pulse", 32'(o_btn_pulse), 32'(m_pulse));
        check_eq("press", 32'(o_btn_press), 32'(m_press));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, pulses, pulses_a, pulses_b, b;
        bit changed;
        idle_vec  = {{NS{1'b0}}, {NB{1'b1}}};
        btn_raw   = '1;
        sw_raw    = '0;
        press_clr = '0;
        rst_n     = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_btn", 32'(o_btn), 32'hF);
        check_eq("rst_sw", 32'(o_sw), 32'h0);
        check_eq("rst_press", 32'(o_btn_press), 32'h0);
        rst_n = 1'b1;

        // 1: idle after reset
        repeat (50) begin
            step();
            check_eq("t1_no_pulse", 32'(o_btn_pulse), 32'h0);
        end

        // 2: clean press of button 1
        btn_raw[1] = 1'b0;
        n = 0; changed = 0; pulses = 0;
        while (!changed && n < 30) begin
            step();
            n++;
            if (o_btn_pulse != 0) pulses++;
            if (o_btn[1] == 1'b0) begin
                changed = 1;
                check_eq("t2_pulse_at_change", 32'(o_btn_pulse), 32'h2);
            end
        end
        check_eq("t2_latency_ok", 32'(changed && n >= 9 && n <= 14), 32'h1);
        repeat (5) begin
            step();
            if (o_btn_pulse != 0) pulses++;
        end
        check_eq("t2_pulse_count", 32'(pulses), 32'h1);
        check_eq("t2_press", 32'(o_btn_press), 32'h2);
        btn_raw[1] = 1'b1;
        pulses = 0;
        repeat (20) begin
            step();
            if (o_btn_pulse != 0) pulses++;
        end
        check_eq("t2_release_no_pulse", 32'(pulses), 32'h0);
        check_eq("t2_released", 32'(o_btn[1]), 32'h1);
        check_eq("t2_press_sticky", 32'(o_btn_press[1]), 32'h1);

        // 3: bouncing button 2
        pulses_b = 0;
        for (int t = 0; t < 8; t++) begin
            btn_raw[2] = ~btn_raw[2];
            repeat (5) begin
                step();
                if (o_btn_pulse[2]) pulses_b++;
            end
        end
        btn_raw[2] = 1'b0;
        pulses_a = 0;
        repeat (20) begin
            step();
            if (o_btn_pulse[2]) pulses_a++;
        end
        check_eq("t3_pulses_during_bounce", 32'(pulses_b), 32'h0);
        check_eq("t3_pulses_after_settle", 32'(pulses_a), 32'h1);

        // 4: clear held across the setting pulse
        press_clr[0] = 1'b1;
        btn_raw[0]   = 1'b0;
        n = 0;
        while (!o_btn_pulse[0] && n < 30) begin
            step();
            n++;
        end
        check_eq("t4_pulse_seen", 32'(o_btn_pulse[0]), 32'h1);
        step();
        press_clr[0] = 1'b0;
        step();
        check_eq("t4_set_wins", 32'(o_btn_press[0]), 32'h1);
        press_clr[0] = 1'b1;
        step();
        press_clr[0] = 1'b0;
        step();
        check_eq("t4_cleared", 32'(o_btn_press[0]), 32'h0);
        check_eq("t4_other_kept", 32'(o_btn_press[1]), 32'h1);
        btn_raw[0] = 1'b1;
        repeat (16) step();

        // 5: switches and a one-tick glitch
        sw_raw = 10'h2A5;
        n = 0;
        while (o_sw != 10'h2A5 && n < 30) begin
            step();
            n++;
        end
        check_eq("t5_sw", 32'(o_sw), 32'h2A5);
        check_eq("t5_latency_ok", 32'(n <= 14), 32'h1);
        sw_raw[3] = ~sw_raw[3];
        repeat (S) step();
        sw_raw[3] = ~sw_raw[3];
        repeat (20) begin
            step();
            check_eq("t5_glitch_ignored", 32'(o_sw), 32'h2A5);
        end

        // 6: reset in the middle of a press window
        btn_raw[3] = 1'b0;
        repeat (9) step();
        check_eq("t6_not_yet", 32'(o_btn[3]), 32'h1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("t6_async_btn", 32'(o_btn), 32'hF);
        check_eq("t6_async_sw", 32'(o_sw), 32'h0);
        check_eq("t6_async_press", 32'(o_btn_press), 32'h0);
        compare_all();
        repeat (3) step();
        rst_n = 1'b1;
        n = 0;
        while (o_btn[3] !== 1'b0 && n < 30) begin
            step();
            n++;
        end
        check_eq("t6_full_window", 32'(n >= 11 && n <= 14), 32'h1);
        btn_raw[3] = 1'b1;
        repeat (16) step();

        // Random activity on all inputs
        repeat (400) begin
            step();
            if ($urandom_range(0, 9) == 0) begin
                b = int'($urandom_range(0, NT - 1));
                if (b < NB) btn_raw[b] = ~btn_raw[b];
                else        sw_raw[b - NB] = ~sw_raw[b - NB];
            end
            press_clr = ($urandom_range(0, 7) == 0) ? NB'($urandom) : '0;
        end
        press_clr = '0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
